// File: rtl/mdu_sequencer.sv
// Multi-cycle MIPS32 multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, owning the HI/LO registers (MTHI/MTLO writes included).
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: start is accepted only in IDLE; busy stays high until the
    // result is written; done pulses for one cycle once hi/lo hold the result.
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;    // mul: multiplicand; div: divisor
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               sgn_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last;

    assign sgn_op   = ~op[0];
    assign abs_a    = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign abs_b    = (sgn_op && b[WIDTH-1]) ? -b : b;
    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : '0);
    assign div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb};
    assign prod_fix = neg_q ? -p : p;
    assign quo_fix  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign rem_fix  = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    assign last     = (cnt == CW'(WIDTH - 1));

    assign busy      = (state == RUN) || (state == FIXUP);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            // A divide by zero spends a single RUN cycle and skips the iterations.
            RUN:   if (dz || last) state_nx = FIXUP;
            FIXUP: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p           <= '0;
            opb         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (state == IDLE && start) begin
                        cnt         <= '0;
                        is_div      <= op[1];
                        neg_q       <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r       <= sgn_op && a[WIDTH-1];
                        dz          <= op[1] && (b == '0);
                        div_by_zero <= 1'b0;
                        opb         <= op[1] ? abs_b : abs_a;
                        if (op[1] && (b == '0))
                            p <= {a, {WIDTH{1'b1}}};
                        else if (op[1])
                            p <= {{WIDTH{1'b0}}, abs_a};
                        else
                            p <= {{WIDTH{1'b0}}, abs_b};
                    end
                end
                RUN: begin
                    if (!dz) begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            if (!div_diff[WIDTH])
                                p <= {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
                            else
                                p <= {div_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
                        end else begin
                            p <= {mul_sum, p[WIDTH-1:1]};
                        end
                    end
                end
                FIXUP: begin
                    if (dz) begin
                        hi          <= p[2*WIDTH-1:WIDTH];
                        lo          <= p[WIDTH-1:0];
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
